// File: rtl/ledcnt_pkg.sv
// Shared constants and width helper for the LED counter block.
package ledcnt_pkg;

  localparam int MODE_WRAP = 0;
  localparam int MODE_SAT  = 1;

  localparam int BTN_UP   = 0;
  localparam int BTN_DOWN = 1;
  localparam int BTN_CLR  = 2;
  localparam int BTN_LOAD = 3;

  // Bits needed to hold 0..value-1, never less than one bit.
  function automatic int cnt_width(input int value);
    return (value <= 2) ? 1 : $clog2(value);
  endfunction

endpackage

// File: rtl/led_counter_gen2_if.sv
// Button/LED bundle for led_counter_gen2; the counter is the slave side.
interface led_counter_gen2_if #(
  parameter int WIDTH = 4
);

  logic [3:0]       BUTTONS;
  logic [WIDTH-1:0] LEDS;
  logic             TICK;
  logic             WRAP;

  modport master (output BUTTONS, input LEDS, input TICK, input WRAP);
  modport slave  (input BUTTONS, output LEDS, output TICK, output WRAP);

endinterface

// File: rtl/ledcnt_tick_gen.sv
// Clock-enable generator: registered one-cycle TICK every DIV cycles.
module ledcnt_tick_gen
  import ledcnt_pkg::*;
#(
  parameter int DIV = 62500000
) (
  input  logic CLOCK,
  input  logic RESET_N,
  input  logic restart,
  output logic TICK
);

  localparam int            CW   = cnt_width(DIV);
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] div_cnt;

  // restart realigns the period so the next TICK lands DIV cycles later
  always_ff @(posedge CLOCK or negedge RESET_N) begin
    if (!RESET_N) begin
      div_cnt <= '0;
      TICK    <= 1'b0;
    end else if (restart) begin
      div_cnt <= '0;
      TICK    <= 1'b0;
    end else if (div_cnt == LAST) begin
      div_cnt <= '0;
      TICK    <= 1'b1;
    end else begin
      div_cnt <= div_cnt + CW'(1);
      TICK    <= 1'b0;
    end
  end

endmodule

// File: rtl/led_counter_gen2.sv
// Up/down LED counter with wrap or saturate mode and button synchronisers.
// Define LEDCNT_DEBOUNCE_EN to insert a DEBOUNCE_CYCLES filter after each synchroniser.
module led_counter_gen2
  import ledcnt_pkg::*;
#(
  parameter int WIDTH           = 4,
  parameter int DIV             = 62500000,
  parameter int MODE            = 0,
  parameter int LOAD_VAL        = 0,
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic               CLOCK,
  input  logic               RESET_N,
  led_counter_gen2_if.slave  bus
);

  if (WIDTH < 1 || WIDTH > 32 || DIV < 2 || DEBOUNCE_CYCLES < 1 ||
      (MODE != MODE_WRAP && MODE != MODE_SAT)) begin : g_bad_params
    $error("led_counter_gen2: illegal parameter set");
  end

  localparam bit               SATURATE   = (MODE == MODE_SAT);
  localparam logic [WIDTH-1:0] CNT_MAX    = '1;
  localparam logic [WIDTH-1:0] LOAD_TRUNC = WIDTH'(LOAD_VAL);

  logic [3:0]       sync1;
  logic [3:0]       sync2;
  logic [3:0]       level;
  logic             prev_clr;
  logic             prev_load;
  logic             clr_edge;
  logic             load_edge;
  logic             tick;
  logic             step_up;
  logic             step_dn;
  logic [WIDTH-1:0] count;
  logic [WIDTH-1:0] count_next;
  logic             wrap_q;
  logic             wrap_next;

  always_ff @(posedge CLOCK or negedge RESET_N) begin
    if (!RESET_N) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= bus.BUTTONS;
      sync2 <= sync1;
    end
  end

`ifdef LEDCNT_DEBOUNCE_EN
  localparam int            DW      = cnt_width(DEBOUNCE_CYCLES);
  localparam logic [DW-1:0] DB_LAST = DW'(DEBOUNCE_CYCLES - 1);

  for (genvar b = 0; b < 4; b++) begin : g_db
    logic [DW-1:0] db_cnt;
    logic          filt_q;

    // any cycle where the synchronised level agrees with the filter restarts the count
    always_ff @(posedge CLOCK or negedge RESET_N) begin
      if (!RESET_N) begin
        db_cnt <= '0;
        filt_q <= 1'b0;
      end else if (sync2[b] == filt_q) begin
        db_cnt <= '0;
      end else if (db_cnt == DB_LAST) begin
        db_cnt <= '0;
        filt_q <= sync2[b];
      end else begin
        db_cnt <= db_cnt + DW'(1);
      end
    end

    assign level[b] = filt_q;
  end
`else
  assign level = sync2;
`endif

  always_ff @(posedge CLOCK or negedge RESET_N) begin
    if (!RESET_N) begin
      prev_clr  <= 1'b0;
      prev_load <= 1'b0;
    end else begin
      prev_clr  <= level[BTN_CLR];
      prev_load <= level[BTN_LOAD];
    end
  end

  assign clr_edge  = level[BTN_CLR]  & ~prev_clr;
  assign load_edge = level[BTN_LOAD] & ~prev_load;

  ledcnt_tick_gen #(
    .DIV(DIV)
  ) u_tick (
    .CLOCK   (CLOCK),
    .RESET_N (RESET_N),
    .restart (clr_edge),
    .TICK    (tick)
  );

  assign step_up = tick & level[BTN_UP]   & ~level[BTN_DOWN];
  assign step_dn = tick & level[BTN_DOWN] & ~level[BTN_UP];

  // clear beats load beats a tick step; WRAP flags only steps that hit a limit
  always_comb begin
    count_next = count;
    wrap_next  = 1'b0;
    if (clr_edge) begin
      count_next = '0;
    end else if (load_edge) begin
      count_next = LOAD_TRUNC;
    end else if (step_up) begin
      if (count == CNT_MAX) begin
        wrap_next = 1'b1;
        if (!SATURATE) begin
          count_next = '0;
        end
      end else begin
        count_next = count + WIDTH'(1);
      end
    end else if (step_dn) begin
      if (count == '0) begin
        wrap_next = 1'b1;
        if (!SATURATE) begin
          count_next = CNT_MAX;
        end
      end else begin
        count_next = count - WIDTH'(1);
      end
    end
  end

  always_ff @(posedge CLOCK or negedge RESET_N) begin
    if (!RESET_N) begin
      count  <= '0;
      wrap_q <= 1'b0;
    end else begin
      count  <= count_next;
      wrap_q <= wrap_next;
    end
  end

  assign bus.LEDS = count;
  assign bus.TICK = tick;
  assign bus.WRAP = wrap_q;

endmodule
